// File: rtl/regfile_writeback_arbiter.sv
// Writeback arbiter for one thread's register file. It round-robins the single write port
// between ALU and LSU results and keeps a busy scoreboard that the issue stage uses for hazard stalls.
module regfile_writeback_arbiter #(
  parameter int DATA_BITS = 8,
  parameter int NUM_REGS  = 16,
  parameter int RO_BASE   = 13
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        alu_wb_valid,
  input  logic [$clog2(NUM_REGS)-1:0] alu_wb_rd,
  input  logic [DATA_BITS-1:0]        alu_wb_data,
  output logic                        alu_wb_ready,
  input  logic                        lsu_wb_valid,
  input  logic [$clog2(NUM_REGS)-1:0] lsu_wb_rd,
  input  logic [DATA_BITS-1:0]        lsu_wb_data,
  output logic                        lsu_wb_ready,
  input  logic                        issue_valid,
  input  logic [$clog2(NUM_REGS)-1:0] issue_rd,
  output logic [NUM_REGS-1:0]         busy_mask,
  output logic                        reg_write_enable,
  output logic [$clog2(NUM_REGS)-1:0] reg_write_address,
  output logic [DATA_BITS-1:0]        reg_write_data,
  output logic                        ro_write_error
);

  localparam int ADDR_BITS = $clog2(NUM_REGS);
  localparam logic [ADDR_BITS-1:0] RO_ADDR = ADDR_BITS'(RO_BASE);

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSU = 1'b1
  } src_e;

  src_e                 last_grant_q, last_grant_d;
  logic                 we_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 ro_err_q;
  logic [NUM_REGS-1:0]  busy_q, busy_d;

  logic                 grant_alu, grant_lsu;
  logic                 xfer, xfer_ro, wr_ok;
  logic [ADDR_BITS-1:0] xfer_rd;
  logic [DATA_BITS-1:0] xfer_data;

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    grant_alu = 1'b0;
    grant_lsu = 1'b0;
    if (enable && !reset) begin
      if (alu_wb_valid && lsu_wb_valid) begin
        grant_lsu = (last_grant_q == SRC_ALU);
        grant_alu = (last_grant_q == SRC_LSU);
      end else begin
        grant_alu = alu_wb_valid;
        grant_lsu = lsu_wb_valid;
      end
    end
  end

  assign alu_wb_ready = grant_alu;
  assign lsu_wb_ready = grant_lsu;
  assign xfer         = grant_alu | grant_lsu;
  assign xfer_rd      = grant_lsu ? lsu_wb_rd   : alu_wb_rd;
  assign xfer_data    = grant_lsu ? lsu_wb_data : alu_wb_data;
  assign xfer_ro      = (xfer_rd >= RO_ADDR);
  assign wr_ok        = xfer && !xfer_ro;

  always_comb begin
    last_grant_d = last_grant_q;
    if (grant_lsu)      last_grant_d = SRC_LSU;
    else if (grant_alu) last_grant_d = SRC_ALU;
  end

  // The set is applied after the clear, so a same-cycle reissue keeps the newer write marked busy.
  always_comb begin
    busy_d = busy_q;
    if (wr_ok) busy_d[xfer_rd] = 1'b0;
    if (issue_valid && enable && (issue_rd < RO_ADDR)) busy_d[issue_rd] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= SRC_ALU;
      we_q         <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      ro_err_q     <= 1'b0;
      busy_q       <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      we_q         <= wr_ok;
      if (wr_ok) begin
        addr_q <= xfer_rd;
        data_q <= xfer_data;
      end
      ro_err_q <= ro_err_q | (xfer && xfer_ro);
      busy_q   <= busy_d;
    end
  end

  // Reset masks a write that is already registered, so it never reaches the register file.
  assign reg_write_enable  = we_q & ~reset;
  assign reg_write_address = addr_q;
  assign reg_write_data    = data_q;
  assign ro_write_error    = ro_err_q;
  assign busy_mask         = busy_q;

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Bench for regfile_writeback_arbiter. Each cycle predicts the grant and the next port write from a small model,
// queues the write, and compares it after the clock edge; the scenario tasks add targeted checks.
module tb_regfile_writeback_arbiter;

  logic        clk = 1'b0;
  logic        reset, enable;
  logic        alu_wb_valid, lsu_wb_valid, issue_valid;
  logic [3:0]  alu_wb_rd, lsu_wb_rd, issue_rd;
  logic [7:0]  alu_wb_data, lsu_wb_data;
  logic        alu_wb_ready, lsu_wb_ready;
  logic [15:0] busy_mask;
  logic        reg_write_enable;
  logic [3:0]  reg_write_address;
  logic [7:0]  reg_write_data;
  logic        ro_write_error;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic       we;
    logic [3:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t exp_q[$];

  logic        m_last_lsu;
  logic [15:0] m_busy;
  logic        m_err;
  logic [3:0]  m_addr;
  logic [7:0]  m_data;

  always #5 clk = ~clk;

  regfile_writeback_arbiter #(.DATA_BITS(8), .NUM_REGS(16), .RO_BASE(13)) dut (
    .clk              (clk),
    .reset            (reset),
    .enable           (enable),
    .alu_wb_valid     (alu_wb_valid),
    .alu_wb_rd        (alu_wb_rd),
    .alu_wb_data      (alu_wb_data),
    .alu_wb_ready     (alu_wb_ready),
    .lsu_wb_valid     (lsu_wb_valid),
    .lsu_wb_rd        (lsu_wb_rd),
    .lsu_wb_data      (lsu_wb_data),
    .lsu_wb_ready     (lsu_wb_ready),
    .issue_valid      (issue_valid),
    .issue_rd         (issue_rd),
    .busy_mask        (busy_mask),
    .reg_write_enable (reg_write_enable),
    .reg_write_address(reg_write_address),
    .reg_write_data   (reg_write_data),
    .ro_write_error   (ro_write_error)
  );

  task automatic idle();
    alu_wb_valid = 1'b0;
    lsu_wb_valid = 1'b0;
    issue_valid  = 1'b0;
  endtask

  // One clock cycle: predict and check readys, queue the expected port write, then check it after the edge.
  task automatic tick();
    logic       ga, gl, xf, ro;
    logic [3:0] rd;
    logic [7:0] d;
    wr_t        e, got;
    #1;
    ga = 1'b0;
    gl = 1'b0;
    if (enable && !reset) begin
      if (alu_wb_valid && lsu_wb_valid) begin
        gl = !m_last_lsu;
        ga = m_last_lsu;
      end else begin
        ga = alu_wb_valid;
        gl = lsu_wb_valid;
      end
    end
    n_checks++;
    if ({alu_wb_ready, lsu_wb_ready} !== {ga, gl}) begin
      n_fail++;
      $display("FAIL ready: alu/lsu got %b%b expected %b%b", alu_wb_ready, lsu_wb_ready, ga, gl);
    end
    xf = ga | gl;
    rd = gl ? lsu_wb_rd : alu_wb_rd;
    d  = gl ? lsu_wb_data : alu_wb_data;
    ro = (rd >= 4'd13);
    if (reset) begin
      m_busy = '0; m_err = 1'b0; m_last_lsu = 1'b0; m_addr = '0; m_data = '0;
      e = '0;
    end else begin
      if (xf && !ro) begin
        m_addr = rd;
        m_data = d;
        m_busy[rd] = 1'b0;
      end
      if (xf && ro) m_err = 1'b1;
      if (issue_valid && enable && issue_rd < 4'd13) m_busy[issue_rd] = 1'b1;
      if (gl) m_last_lsu = 1'b1;
      else if (ga) m_last_lsu = 1'b0;
      e = {xf && !ro, m_addr, m_data};
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    e.we = e.we & ~reset;
    got = {reg_write_enable, reg_write_address, reg_write_data};
    n_checks++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL port write: got we=%b addr=%0d data=%h expected we=%b addr=%0d data=%h",
               got.we, got.addr, got.data, e.we, e.addr, e.data);
    end
    n_checks++;
    if (busy_mask !== m_busy) begin
      n_fail++;
      $display("FAIL busy_mask: got %h expected %h", busy_mask, m_busy);
    end
    n_checks++;
    if (ro_write_error !== m_err) begin
      n_fail++;
      $display("FAIL ro_write_error: got %b expected %b", ro_write_error, m_err);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; idle();
    alu_wb_rd = '0; lsu_wb_rd = '0; issue_rd = '0; alu_wb_data = '0; lsu_wb_data = '0;
    tick();
    tick();
    n_checks++;
    if ({reg_write_enable, reg_write_address, reg_write_data, busy_mask, ro_write_error} !== 30'd0) begin
      n_fail++;
      $display("FAIL reset state: we=%b addr=%0d data=%h busy=%h err=%b",
               reg_write_enable, reg_write_address, reg_write_data, busy_mask, ro_write_error);
    end
    reset = 1'b0;
  endtask

  task automatic test_alu_single();
    alu_wb_valid = 1'b1; alu_wb_rd = 4'd3; alu_wb_data = 8'h5A;
    tick();
    n_checks++;
    if ({reg_write_enable, reg_write_address, reg_write_data} !== {1'b1, 4'd3, 8'h5A}) begin
      n_fail++;
      $display("FAIL alu single: got we=%b addr=%0d data=%h expected we=1 addr=3 data=5a",
               reg_write_enable, reg_write_address, reg_write_data);
    end
    idle();
    tick();
    n_checks++;
    if (reg_write_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL alu pulse: we got %b expected 0", reg_write_enable);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_addr [4];
    exp_addr = '{4'd1, 4'd2, 4'd1, 4'd2};
    alu_wb_valid = 1'b1; alu_wb_rd = 4'd2; alu_wb_data = 8'hA2;
    lsu_wb_valid = 1'b1; lsu_wb_rd = 4'd1; lsu_wb_data = 8'hB1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (reg_write_address !== exp_addr[i] || reg_write_enable !== 1'b1) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: addr got %0d expected %0d, we got %b", i,
                 reg_write_address, exp_addr[i], reg_write_enable);
      end
    end
    idle();
    tick();
  endtask

  task automatic test_scoreboard();
    issue_valid = 1'b1; issue_rd = 4'd4;
    tick();
    idle();
    n_checks++;
    if (busy_mask !== 16'h0010) begin
      n_fail++;
      $display("FAIL sb issue: busy got %h expected 0010", busy_mask);
    end
    lsu_wb_valid = 1'b1; lsu_wb_rd = 4'd4; lsu_wb_data = 8'h44;
    tick();
    idle();
    n_checks++;
    if (busy_mask !== 16'h0000) begin
      n_fail++;
      $display("FAIL sb clear: busy got %h expected 0000", busy_mask);
    end
    issue_valid = 1'b1; issue_rd = 4'd4;
    tick();
    lsu_wb_valid = 1'b1; lsu_wb_rd = 4'd4; lsu_wb_data = 8'h45;
    tick();
    idle();
    n_checks++;
    if (busy_mask !== 16'h0010) begin
      n_fail++;
      $display("FAIL sb set_wins: busy got %h expected 0010", busy_mask);
    end
    lsu_wb_valid = 1'b1;
    tick();
    idle();
    tick();
  endtask

  task automatic test_read_only();
    alu_wb_valid = 1'b1; alu_wb_rd = 4'd14; alu_wb_data = 8'hFF;
    #1;
    n_checks++;
    if (alu_wb_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ro ready: got %b expected 1", alu_wb_ready);
    end
    tick();
    idle();
    n_checks++;
    if (reg_write_enable !== 1'b0 || ro_write_error !== 1'b1) begin
      n_fail++;
      $display("FAIL ro write: we got %b expected 0, err got %b expected 1", reg_write_enable, ro_write_error);
    end
    issue_valid = 1'b1; issue_rd = 4'd15;
    tick();
    idle();
    tick();
    n_checks++;
    if (busy_mask !== 16'h0000 || ro_write_error !== 1'b1) begin
      n_fail++;
      $display("FAIL ro sticky: busy got %h expected 0000, err got %b expected 1", busy_mask, ro_write_error);
    end
  endtask

  task automatic test_enable();
    issue_valid = 1'b1; issue_rd = 4'd6;
    tick();
    idle();
    enable = 1'b0;
    alu_wb_valid = 1'b1; alu_wb_rd = 4'd2; alu_wb_data = 8'h12;
    lsu_wb_valid = 1'b1; lsu_wb_rd = 4'd1; lsu_wb_data = 8'h21;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (busy_mask !== 16'h0040 || reg_write_enable !== 1'b0) begin
        n_fail++;
        $display("FAIL enable_off[%0d]: busy got %h expected 0040, we got %b expected 0", i,
                 busy_mask, reg_write_enable);
      end
    end
    enable = 1'b1;
    #1;
    n_checks++;
    if ({lsu_wb_ready, alu_wb_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL enable_on: lsu/alu ready got %b%b expected 10", lsu_wb_ready, alu_wb_ready);
    end
    tick();
    lsu_wb_valid = 1'b0;
    tick();
    idle();
    tick();
  endtask

  task automatic test_reset_mid();
    alu_wb_valid = 1'b1; alu_wb_rd = 4'd5; alu_wb_data = 8'h33;
    issue_valid = 1'b1; issue_rd = 4'd7;
    tick();
    idle();
    reset = 1'b1;
    #1;
    n_checks++;
    if (reg_write_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid discard: we got %b expected 0", reg_write_enable);
    end
    tick();
    n_checks++;
    if (reg_write_enable !== 1'b0 || busy_mask !== 16'h0000 || ro_write_error !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid state: we=%b busy=%h err=%b expected 0/0000/0",
               reg_write_enable, busy_mask, ro_write_error);
    end
    reset = 1'b0;
    tick();
  endtask

  initial begin
    m_last_lsu = 1'b0; m_busy = '0; m_err = 1'b0; m_addr = '0; m_data = '0;
    test_reset();
    test_alu_single();
    test_back_to_back();
    test_scoreboard();
    test_read_only();
    test_enable();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
